// File: rtl/serial_strobe_tx_pkg.sv
// serial_strobe_pkg: shared constants for the serial strobe transmitter.
// Holds the FSM state encoding, the phase-counter width and parameter defaults.
// Optional feature macro: SERIAL_STROBE_TX_PARITY_EN (appends an even-parity bit).
package serial_strobe_pkg;

    localparam int CNT_W     = 4;
    localparam int WIDTH_DEF = 8;
    localparam int SETUP_DEF = 1;
    localparam int HOLD_DEF  = 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETUP    = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

    // Number of strobed bits per frame for a given payload width.
    function automatic int frame_bits(input int width);
`ifdef SERIAL_STROBE_TX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/serial_strobe_tx_if.sv
// serial_strobe_tx_if: producer handshake plus serial output lines.
//
// Handshake: the producer drives dav_ low to offer data. The transmitter
// accepts on a rising clock edge where it is idle (rfd=1) and dav_=0, and
// samples data only at that edge. After a frame completes the transmitter
// waits for dav_ to return high before it raises rfd again, so one low
// period of dav_ can never launch two frames.
interface serial_strobe_tx_if #(
    parameter int WIDTH = serial_strobe_pkg::WIDTH_DEF
);
    logic             dav_;
    logic [WIDTH-1:0] data;
    logic             rfd;
    logic             d;
    logic             p;
    logic             busy;

    modport master (output dav_, output data, input rfd, input d, input p, input busy);
    modport slave  (input dav_, input data, output rfd, output d, output p, output busy);
endinterface

// File: rtl/serial_strobe_tx_strobe_timer.sv
// strobe_timer: loadable down-counter with terminal-count flag.
// Times the SETUP and HOLD phases; sits at zero once expired.
module strobe_timer
    import serial_strobe_pkg::*;
(
    input  logic             clock,
    input  logic             reset_,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/serial_strobe_tx.sv
// serial_strobe_tx: shifts a parallel word out LSB first on d, with a strobe
// p whose rising edge clocks an edge-triggered receiver. d is set up for
// SETUP_CYC cycles with p low, then held for HOLD_CYC cycles with p high.
// Optional feature macro: SERIAL_STROBE_TX_PARITY_EN (extra even-parity bit
// sent after the payload).
module serial_strobe_tx
    import serial_strobe_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int SETUP_CYC = SETUP_DEF,
    parameter int HOLD_CYC  = HOLD_DEF
) (
    input  logic               clock,
    input  logic               reset_,
    serial_strobe_tx_if.slave  bus,
    output logic [1:0]         state_dbg
);

    localparam int NBITS = frame_bits(WIDTH);
    localparam int IDX_W = $clog2(NBITS + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NBITS - 1);

    logic [1:0]       state;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] shreg_next;
    logic [NBITS-1:0] frame_word;
    logic [IDX_W-1:0] bit_idx;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_tc;

`ifdef SERIAL_STROBE_TX_PARITY_EN
    assign frame_word = {^bus.data, bus.data};
`else
    assign frame_word = bus.data;
`endif

    assign shreg_next = shreg >> 1;
    assign state_dbg  = state;

    strobe_timer u_timer (
        .clock    (clock),
        .reset_   (reset_),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .tc       (tmr_tc)
    );

    // Reload the phase timer on every transition into SETUP or HOLD.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SETUP_LOAD;
        case (state)
            ST_IDLE: begin
                if (!bus.dav_) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (tmr_tc && (bit_idx != LAST_IDX)) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LOAD;
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    // Frame FSM; every output is a register updated alongside the state.
    // bit_idx only advances below LAST_IDX, so it can never wrap into an
    // extra bit.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            bus.d    <= 1'b0;
            bus.p    <= 1'b0;
            bus.busy <= 1'b0;
            bus.rfd  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!bus.dav_) begin
                        state    <= ST_SETUP;
                        shreg    <= frame_word;
                        bit_idx  <= '0;
                        bus.d    <= frame_word[0];
                        bus.p    <= 1'b0;
                        bus.busy <= 1'b1;
                        bus.rfd  <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (tmr_tc) begin
                        state <= ST_HOLD;
                        bus.p <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (tmr_tc) begin
                        bus.p <= 1'b0;
                        if (bit_idx == LAST_IDX) begin
                            state    <= ST_WAIT_ACK;
                            shreg    <= '0;
                            bus.d    <= 1'b0;
                            bus.busy <= 1'b0;
                        end else begin
                            state   <= ST_SETUP;
                            shreg   <= shreg_next;
                            bus.d   <= shreg_next[0];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (bus.dav_) begin
                        state   <= ST_IDLE;
                        bus.rfd <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_strobe_tx.sv
// tb_serial_strobe_tx: drives two transmitters (SETUP/HOLD = 1/1 and 3/2)
// from one producer and checks them with a strobe-edge receiver model.
module tb_serial_strobe_tx;
    import serial_strobe_pkg::*;

    localparam int W  = 8;
    localparam int SA = 1;
    localparam int HA = 1;
    localparam int SB = 3;
    localparam int HB = 2;
`ifdef SERIAL_STROBE_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    logic         clock  = 1'b0;
    logic         reset_ = 1'b0;
    logic         dav_   = 1'b1;
    logic [W-1:0] data   = '0;
    always #5 clock = ~clock;

    serial_strobe_tx_if #(.WIDTH(W)) if_a ();
    serial_strobe_tx_if #(.WIDTH(W)) if_b ();
    assign if_a.dav_ = dav_;
    assign if_a.data = data;
    assign if_b.dav_ = dav_;
    assign if_b.data = data;

    logic [1:0] st_a;
    logic [1:0] st_b;

    serial_strobe_tx #(.WIDTH(W), .SETUP_CYC(SA), .HOLD_CYC(HA)) dut_a (
        .clock(clock), .reset_(reset_), .bus(if_a), .state_dbg(st_a));
    serial_strobe_tx #(.WIDTH(W), .SETUP_CYC(SB), .HOLD_CYC(HB)) dut_b (
        .clock(clock), .reset_(reset_), .bus(if_b), .state_dbg(st_b));

    wire [1:0] p_v    = {if_b.p, if_a.p};
    wire [1:0] d_v    = {if_b.d, if_a.d};
    wire [1:0] busy_v = {if_b.busy, if_a.busy};
    wire [1:0] rfd_v  = {if_b.rfd, if_a.rfd};

    // ---------------- reference model ----------------
    function automatic int s_of(input int i);
        return (i == 0) ? SA : SB;
    endfunction
    function automatic int h_of(input int i);
        return (i == 0) ? HA : HB;
    endfunction
    function automatic int exp_len(input int i);
        return NB * (s_of(i) + h_of(i));
    endfunction
    // Word a receiver reassembles: payload bits in order, then even parity.
    function automatic logic [NB-1:0] exp_word(input logic [W-1:0] v);
        logic [NB-1:0] e;
        e = '0;
        for (int b = 0; b < W; b++) e[b] = v[b];
`ifdef SERIAL_STROBE_TX_PARITY_EN
        e[NB-1] = (($countones(v) % 2) == 1);
`endif
        return e;
    endfunction

    // ---------------- receiver / waveform monitor ----------------
    // A D flip-flop clocked by p feeding a shift register (first bit ends at
    // LSB), plus run-length checks on the p waveform and d stability.
    int            low_run[2], high_run[2], busy_cyc[2], rise_cnt[2];
    int            total_rises[2] = '{0, 0};
    int            frames_done[2] = '{0, 0};
    int            shape_err[2]   = '{0, 0};
    int            stab_err[2]    = '{0, 0};
    int            last_len[2], last_rises[2];
    logic [NB-1:0] rx_sh[2], last_word[2];
    logic          prev_p[2], prev_d[2], prev_busy[2];

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_) begin
                low_run[i]   <= 0;
                high_run[i]  <= 0;
                busy_cyc[i]  <= 0;
                rise_cnt[i]  <= 0;
                rx_sh[i]     <= '0;
                prev_p[i]    <= 1'b0;
                prev_d[i]    <= 1'b0;
                prev_busy[i] <= 1'b0;
            end else begin
                prev_p[i]    <= p_v[i];
                prev_d[i]    <= d_v[i];
                prev_busy[i] <= busy_v[i];
                if (p_v[i] && (d_v[i] !== prev_d[i])) stab_err[i] <= stab_err[i] + 1;
                if (p_v[i] && !prev_p[i]) begin
                    if (low_run[i] != s_of(i)) shape_err[i] <= shape_err[i] + 1;
                    low_run[i]     <= 0;
                    high_run[i]    <= 1;
                    rx_sh[i]       <= {d_v[i], rx_sh[i][NB-1:1]};
                    rise_cnt[i]    <= rise_cnt[i] + 1;
                    total_rises[i] <= total_rises[i] + 1;
                end else if (p_v[i]) begin
                    high_run[i] <= high_run[i] + 1;
                end
                if (!p_v[i] && prev_p[i]) begin
                    if (high_run[i] != h_of(i)) shape_err[i] <= shape_err[i] + 1;
                    high_run[i] <= 0;
                end
                if (!p_v[i] && busy_v[i]) low_run[i] <= low_run[i] + 1;
                if (busy_v[i]) busy_cyc[i] <= busy_cyc[i] + 1;
                if (!busy_v[i] && prev_busy[i]) begin
                    last_len[i]    <= busy_cyc[i];
                    last_word[i]   <= rx_sh[i];
                    last_rises[i]  <= rise_cnt[i];
                    frames_done[i] <= frames_done[i] + 1;
                    busy_cyc[i]    <= 0;
                    rise_cnt[i]    <= 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Advance n clocks; inputs change and outputs are read just after negedge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (!(rfd_v[0] && rfd_v[1]) && n < 400) begin
            cyc(1);
            n++;
        end
        ok = rfd_v[0] && rfd_v[1];
    endtask

    task automatic wait_done(input int t0, input int t1, output bit ok);
        int n;
        n = 0;
        while ((frames_done[0] < t0 || frames_done[1] < t1) && n < 400) begin
            cyc(1);
            n++;
        end
        ok = (frames_done[0] >= t0) && (frames_done[1] >= t1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_ = 1'b0;
        dav_   = 1'b1;
        cyc(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({rfd_v[i], p_v[i], d_v[i], busy_v[i]} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_outputs[%0d]: rfd,p,d,busy=%b required 1000", i,
                         {rfd_v[i], p_v[i], d_v[i], busy_v[i]});
            end
        end
        checks++;
        if (st_a !== ST_IDLE || st_b !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state: a=%0d b=%0d required %0d", st_a, st_b, ST_IDLE);
        end
        reset_ = 1'b1;
        cyc(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rfd_v[i] !== 1'b1 || busy_v[i] !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset[%0d]: rfd=%b busy=%b required 1 0", i, rfd_v[i], busy_v[i]);
            end
        end
    endtask

    task automatic test_known_word();
        int b0, b1;
        bit ok;
        wait_idle(ok);
        b0 = frames_done[0];
        b1 = frames_done[1];
        data = 8'hA5;
        dav_ = 1'b0;
        cyc(1);
        dav_ = 1'b1;
        data = 8'h00;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy_v[i] !== 1'b1 || rfd_v[i] !== 1'b0) begin
                failures++;
                $display("FAIL accept[%0d]: busy=%b rfd=%b required 1 0", i, busy_v[i], rfd_v[i]);
            end
        end
        wait_done(b0 + 1, 0, ok);
        checks++;
        if (!ok || st_a !== ST_WAIT_ACK || rfd_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL a5_wait_ack: done=%0b state=%0d rfd=%b required 1 %0d 0", ok, st_a, rfd_v[0], ST_WAIT_ACK);
        end
        wait_done(b0 + 1, b1 + 1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL a5_timeout: frames=%0d/%0d required %0d/%0d", frames_done[0], frames_done[1], b0 + 1, b1 + 1);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (last_word[i] !== exp_word(8'hA5)) begin
                failures++;
                $display("FAIL a5_word[%0d]: got %h required %h", i, last_word[i], exp_word(8'hA5));
            end
            checks++;
            if (last_len[i] != exp_len(i) || last_rises[i] != NB) begin
                failures++;
                $display("FAIL a5_len[%0d]: cycles=%0d edges=%0d required %0d %0d", i, last_len[i], last_rises[i], exp_len(i), NB);
            end
        end
    endtask

    task automatic test_hold_dav();
        int b0, b1;
        bit ok;
        logic [W-1:0] v;
        wait_idle(ok);
        v = W'($urandom);
        b0 = frames_done[0];
        b1 = frames_done[1];
        data = v;
        dav_ = 1'b0;
        wait_done(b0 + 1, b1 + 1, ok);
        cyc(5);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rfd_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || frames_done[i] != ((i == 0) ? b0 : b1) + 1) begin
                failures++;
                $display("FAIL hold_dav[%0d]: rfd=%b busy=%b frames=%0d required 0 0 %0d", i, rfd_v[i], busy_v[i],
                         frames_done[i], ((i == 0) ? b0 : b1) + 1);
            end
            checks++;
            if (last_word[i] !== exp_word(v)) begin
                failures++;
                $display("FAIL hold_word[%0d]: got %h required %h", i, last_word[i], exp_word(v));
            end
        end
        dav_ = 1'b1;
        cyc(1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rfd_v[i] !== 1'b1) begin
                failures++;
                $display("FAIL release_rfd[%0d]: rfd=%b required 1", i, rfd_v[i]);
            end
        end
    endtask

    task automatic test_parity();
        logic [W-1:0] pats[2];
        int b0, b1;
        bit ok;
        pats[0] = 8'h07;
        pats[1] = 8'h03;
        for (int k = 0; k < 2; k++) begin
            wait_idle(ok);
            b0 = frames_done[0];
            b1 = frames_done[1];
            data = pats[k];
            dav_ = 1'b0;
            cyc(1);
            dav_ = 1'b1;
            wait_done(b0 + 1, b1 + 1, ok);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (!ok || last_word[i] !== exp_word(pats[k]) || last_rises[i] != NB) begin
                    failures++;
                    $display("FAIL parity_frame[%0d] data=%h: word=%h edges=%0d required %h %0d", i, pats[k],
                             last_word[i], last_rises[i], exp_word(pats[k]), NB);
                end
`ifdef SERIAL_STROBE_TX_PARITY_EN
                checks++;
                if (last_word[i][NB-1] !== ((k == 0) ? 1'b1 : 1'b0)) begin
                    failures++;
                    $display("FAIL parity_bit[%0d] data=%h: got %b required %b", i, pats[k], last_word[i][NB-1],
                             (k == 0) ? 1'b1 : 1'b0);
                end
`endif
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int b0, b1, n;
        int r_before[2];
        bit ok;
        logic [W-1:0] v2;
        wait_idle(ok);
        b0 = frames_done[0];
        b1 = frames_done[1];
        data = W'($urandom);
        dav_ = 1'b0;
        cyc(1);
        dav_ = 1'b1;
        n = 0;
        while (!(rise_cnt[0] == 4 && p_v[0]) && n < 100) begin
            cyc(1);
            n++;
        end
        checks++;
        if (!(rise_cnt[0] == 4 && p_v[0])) begin
            failures++;
            $display("FAIL reach_bit4_hold: edges=%0d p=%b required 4 1", rise_cnt[0], p_v[0]);
        end
        r_before[0] = total_rises[0];
        r_before[1] = total_rises[1];
        v2 = W'($urandom);
        reset_ = 1'b0;
        dav_   = 1'b0;
        data   = v2;
        cyc(1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({rfd_v[i], p_v[i], d_v[i], busy_v[i]} !== 4'b1000) begin
                failures++;
                $display("FAIL midframe_reset[%0d]: rfd,p,d,busy=%b required 1000", i,
                         {rfd_v[i], p_v[i], d_v[i], busy_v[i]});
            end
        end
        cyc(1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rfd_v[i] !== 1'b1 || busy_v[i] !== 1'b0) begin
                failures++;
                $display("FAIL dav_during_reset[%0d]: rfd=%b busy=%b required 1 0", i, rfd_v[i], busy_v[i]);
            end
        end
        reset_ = 1'b1;
        cyc(1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy_v[i] !== 1'b1 || total_rises[i] != r_before[i]) begin
                failures++;
                $display("FAIL accept_after_reset[%0d]: busy=%b extra_edges=%0d required 1 0", i, busy_v[i],
                         total_rises[i] - r_before[i]);
            end
        end
        dav_ = 1'b1;
        wait_done(b0 + 1, b1 + 1, ok);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (!ok || frames_done[i] != ((i == 0) ? b0 : b1) + 1 || last_word[i] !== exp_word(v2)) begin
                failures++;
                $display("FAIL post_reset_frame[%0d]: frames=%0d word=%h required %0d %h", i, frames_done[i],
                         last_word[i], ((i == 0) ? b0 : b1) + 1, exp_word(v2));
            end
        end
    endtask

    task automatic test_random_frames();
        int b0, b1, hold;
        bit ok;
        logic [W-1:0] v;
        for (int f = 0; f < 1000; f++) begin
            wait_idle(ok);
            v = W'($urandom);
            b0 = frames_done[0];
            b1 = frames_done[1];
            data = v;
            dav_ = 1'b0;
            cyc(1);
            hold = $urandom_range(0, 20);
            for (int k = 0; k < hold; k++) begin
                data = W'($urandom);
                cyc(1);
            end
            dav_ = 1'b1;
            data = W'($urandom);
            wait_done(b0 + 1, b1 + 1, ok);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (!ok || frames_done[i] != ((i == 0) ? b0 : b1) + 1 || last_word[i] !== exp_word(v)) begin
                    failures++;
                    $display("FAIL rand_word[%0d] frame %0d: frames=%0d word=%h required %0d %h", i, f,
                             frames_done[i], last_word[i], ((i == 0) ? b0 : b1) + 1, exp_word(v));
                end
                checks++;
                if (last_len[i] != exp_len(i) || last_rises[i] != NB) begin
                    failures++;
                    $display("FAIL rand_len[%0d] frame %0d: cycles=%0d edges=%0d required %0d %0d", i, f,
                             last_len[i], last_rises[i], exp_len(i), NB);
                end
            end
        end
    endtask

    task automatic test_waveform_rules();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (shape_err[i] != 0) begin
                failures++;
                $display("FAIL strobe_shape[%0d]: bad phase lengths=%0d required 0", i, shape_err[i]);
            end
            checks++;
            if (stab_err[i] != 0) begin
                failures++;
                $display("FAIL d_stability[%0d]: d changes with p high=%0d required 0", i, stab_err[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_known_word();
        test_hold_dav();
        test_parity();
        test_reset_mid_frame();
        test_random_frames();
        test_waveform_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_strobe_tx.md
SERIAL_STROBE_TX -- requirements
Module: serial_strobe_tx

Interface
REQ-001 Parameter WIDTH, default 8, number of payload bits per frame.
REQ-002 Parameter SETUP_CYC, default 1, range 1..15; clock cycles d is stable with p low before each p rising edge.
REQ-003 Parameter HOLD_CYC, default 1, range 1..15; clock cycles p stays high and d stays stable after each p rising edge.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_  input  1  reset, synchronous and active-low.
REQ-006 dav_  input  1  data-available from producer, active-low.
REQ-007 data  input  WIDTH  parallel word; sampled only at acceptance.
REQ-008 rfd  output  1  ready-for-data to producer, active-high.
REQ-009 d  output  1  serial data line, for a positive-edge-triggered D flip-flop receiver.
REQ-010 p  output  1  strobe line; the receiver samples d on each 0->1 transition of p.
REQ-011 busy  output  1  high while a frame is being shifted out.

Function
REQ-012 States: IDLE, SETUP, HOLD, WAIT_ACK; all outputs registered.
REQ-013 IDLE: rfd=1, p=0, d=0, busy=0; dav_=0 at an edge captures data into the shift register, clears the bit index, and enters SETUP.
REQ-014 SETUP: d=current bit (LSB first), p=0, busy=1, rfd=0; after SETUP_CYC cycles, enters HOLD.
REQ-015 HOLD: p=1, d unchanged; after HOLD_CYC cycles, if bits remain, shift and enter SETUP (d changes in the same cycle p falls); otherwise enter WAIT_ACK.
REQ-016 WAIT_ACK: p=0, d=0, busy=0, rfd=0; dav_=1 at an edge moves to IDLE, so rfd rises one cycle later.
REQ-017 Frame length: NBITS*(SETUP_CYC+HOLD_CYC) cycles, with NBITS=WIDTH (or WIDTH+1, see REQ-024); exactly NBITS p rising edges per frame.
REQ-018 d never changes while p=1 and never changes in the cycle p rises.
REQ-019 Changes on dav_ or data outside IDLE are ignored; no second frame starts until dav_ has returned to 1.
REQ-020 Cycle and bit counters saturate at their terminal value; no wrap-around into a spurious extra bit.

Reset
REQ-021 reset_=0 at an edge forces IDLE, p=0, d=0, busy=0, rfd=1, and clears counters and the shift register, in any state including mid-frame.
REQ-022 A frame interrupted by reset emits no further p edges; the partial frame is not resumed.
REQ-023 dav_=0 is not accepted in a cycle where reset_=0; it is accepted at the first edge with reset_=1.

Configuration
REQ-024 Macro SERIAL_STROBE_TX_PARITY_EN: when defined, NBITS=WIDTH+1 and the final bit is even parity (XOR of data); when undefined, NBITS=WIDTH and no parity bit is sent.

Structure
REQ-025 Package serial_strobe_pkg holds the state encoding, the counter width (4 bits) and the parameter defaults.
REQ-026 Sub-module strobe_timer is a loadable down-counter with a terminal-count flag, used for the SETUP and HOLD phase durations.

Verification
REQ-027 WIDTH=8, SETUP=HOLD=1, data=8'hA5, dav_ pulsed low -> d sampled at the 8 p rising edges = 1,0,1,0,0,1,0,1; frame lasts 16 cycles; then WAIT_ACK.
REQ-028 SETUP=3, HOLD=2 -> each bit shows p=0 for 3 cycles then p=1 for 2 cycles; d stable across all 5 cycles; 40-cycle frame.
REQ-029 dav_ held low after the frame -> rfd stays 0, no second frame; dav_ raised -> rfd=1 one cycle later.
REQ-030 reset_=0 during the 4th bit's HOLD phase -> next cycle p=0, d=0, rfd=1, busy=0; no further p edges.
REQ-031 PARITY_EN defined, data=8'h07 -> 9 p edges, 9th sampled bit=1; with data=8'h03 the 9th sampled bit=0.
REQ-032 Receiver model (7474-style flip-flop plus shift register) reassembles the word for random data over 1000 frames with zero mismatches.
